// File: rtl/pci_cfg_front_if.sv
// Signal bundle between the PCI bus, the config target front end and the user logic.
// The "slave" modport is the target's view; "master" is the bus initiator plus user side.
interface pci_cfg_front_if;
    // PCI bus side
    logic        FRAME_N;
    logic        IRDY_N;
    logic        IDSEL;
    logic [3:0]  CBE_N;
    logic [31:0] AD_in;
    logic        DEVSEL_N;
    logic        TRDY_N;
    logic        STOP_N;
    logic [31:0] AD_out;
    logic        AD_oe;

    // user side
    logic        cfg_vld;
    logic        cfg_hit;
    logic        s_wrdn;
    logic        s_data;
    logic        s_data_vld;
    logic [31:0] addr;
    logic [31:0] adio_out;
    logic [31:0] adio_in;
    logic        c_ready;
    logic        c_term;

    modport slave (
        input  FRAME_N, IRDY_N, IDSEL, CBE_N, AD_in, adio_in, c_ready, c_term,
        output DEVSEL_N, TRDY_N, STOP_N, AD_out, AD_oe,
        output cfg_vld, cfg_hit, s_wrdn, s_data, s_data_vld, addr, adio_out
    );

    modport master (
        output FRAME_N, IRDY_N, IDSEL, CBE_N, AD_in, adio_in, c_ready, c_term,
        input  DEVSEL_N, TRDY_N, STOP_N, AD_out, AD_oe,
        input  cfg_vld, cfg_hit, s_wrdn, s_data, s_data_vld, addr, adio_out
    );
endinterface

// File: rtl/pci_cfg_front.sv
// PCI configuration-space target front end.
// Decodes type-0 config read/write address phases, hands each data phase to
// the user logic (c_ready = complete, c_term = disconnect), runs a 16-cycle
// watchdog that target-aborts an unresponsive user, and inserts one
// turnaround cycle before going idle. Every output comes straight from a flop.
module pci_cfg_front (
    input  logic           CLK,
    input  logic           reset_n,
    pci_cfg_front_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        DATA,
        TURN,
        BUSY
    } state_t;

    // All registered outputs plus the watchdog, kept together so the next-state
    // logic can start from "hold everything" and only touch what changes.
    typedef struct packed {
        logic        devsel_n;
        logic        trdy_n;
        logic        stop_n;
        logic        ad_oe;
        logic        cfg_vld;
        logic        cfg_hit;
        logic        s_wrdn;
        logic        s_data;
        logic        s_data_vld;
        logic [31:0] ad_out;
        logic [31:0] addr;
        logic [31:0] adio_out;
        logic [4:0]  wdog;
    } regs_t;

    localparam regs_t REGS_RESET = '{
        devsel_n: 1'b1,
        trdy_n:   1'b1,
        stop_n:   1'b1,
        default:  '0
    };

    state_t state;
    state_t state_nx;
    regs_t  r;
    regs_t  r_nx;

    logic addr_ok;
    logic xfer;
    logic go_turn;

    assign addr_ok = bus.IDSEL && (bus.AD_in[1:0] == 2'b00) &&
                     ((bus.CBE_N == 4'hA) || (bus.CBE_N == 4'hB));
    assign xfer    = !r.trdy_n && !bus.IRDY_N;

    // Next-state and next-output decision for every state.
    always_comb begin
        state_nx       = state;
        r_nx           = r;
        r_nx.cfg_vld   = 1'b0;
        r_nx.cfg_hit   = 1'b0;
        r_nx.s_data_vld = 1'b0;
        go_turn        = 1'b0;

        case (state)
            IDLE: begin
                if (!bus.FRAME_N) begin
                    if (addr_ok) begin
                        r_nx.addr    = bus.AD_in;
                        r_nx.s_wrdn  = bus.CBE_N[0];
                        r_nx.cfg_vld = 1'b1;
                        state_nx     = DECODE;
                    end else begin
                        state_nx = BUSY;
                    end
                end
            end

            BUSY: begin
                if (bus.FRAME_N && bus.IRDY_N) begin
                    state_nx = IDLE;
                end
            end

            DECODE: begin
                r_nx.cfg_hit  = 1'b1;
                r_nx.devsel_n = 1'b0;
                r_nx.s_data   = 1'b1;
                r_nx.ad_oe    = !r.s_wrdn;
                r_nx.wdog     = 5'd0;
                state_nx      = DATA;
            end

            DATA: begin
                if (xfer) begin
                    // A data word moved; the user's answer for the next phase
                    // is only looked at from the following edge onwards.
                    r_nx.s_data_vld = 1'b1;
                    if (r.s_wrdn) begin
                        r_nx.adio_out = bus.AD_in;
                    end
                    r_nx.addr[7:2] = r.addr[7:2] + 6'd1;
                    r_nx.wdog      = 5'd0;
                    if (!r.stop_n || bus.FRAME_N) begin
                        go_turn = 1'b1;
                    end else begin
                        r_nx.trdy_n = 1'b1;
                    end
                end else if (!r.stop_n && r.trdy_n) begin
                    // Retry, disconnect without data or target abort: wait
                    // for the initiator to end the frame.
                    if (bus.FRAME_N) begin
                        go_turn = 1'b1;
                    end
                end else if (r.trdy_n) begin
                    r_nx.wdog = r.wdog + 5'd1;
                    if (bus.c_ready) begin
                        r_nx.trdy_n = 1'b0;
                        if (!r.s_wrdn) begin
                            r_nx.ad_out = bus.adio_in;
                        end
                    end
                    if (bus.c_term) begin
                        r_nx.stop_n = 1'b0;
                    end
                    if (!bus.c_ready && !bus.c_term && (r.wdog == 5'd15)) begin
                        r_nx.stop_n   = 1'b0;
                        r_nx.devsel_n = 1'b1;
                    end
                end
            end

            TURN: begin
                state_nx = IDLE;
            end

            default: begin
                state_nx = IDLE;
            end
        endcase

        if (go_turn) begin
            r_nx.devsel_n = 1'b1;
            r_nx.trdy_n   = 1'b1;
            r_nx.stop_n   = 1'b1;
            r_nx.ad_oe    = 1'b0;
            r_nx.s_data   = 1'b0;
            state_nx      = TURN;
        end
    end

    // State and output registers; reset wins over any transition.
    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            state <= IDLE;
            r     <= REGS_RESET;
        end else begin
            state <= state_nx;
            r     <= r_nx;
        end
    end

    assign bus.DEVSEL_N   = r.devsel_n;
    assign bus.TRDY_N     = r.trdy_n;
    assign bus.STOP_N     = r.stop_n;
    assign bus.AD_out     = r.ad_out;
    assign bus.AD_oe      = r.ad_oe;
    assign bus.cfg_vld    = r.cfg_vld;
    assign bus.cfg_hit    = r.cfg_hit;
    assign bus.s_wrdn     = r.s_wrdn;
    assign bus.s_data     = r.s_data;
    assign bus.s_data_vld = r.s_data_vld;
    assign bus.addr       = r.addr;
    assign bus.adio_out   = r.adio_out;

endmodule

// File: tb/tb_pci_cfg_front.sv
// Self-checking bench for pci_cfg_front: directed protocol scenarios followed by
// randomized config transactions, all checked against a transaction-level model.
module tb_pci_cfg_front;

    logic CLK = 1'b0;
    logic reset_n;

    pci_cfg_front_if bus ();

    pci_cfg_front dut (
        .CLK     (CLK),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Free-running 100 MHz clock.
    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // Model of the values the target should currently be holding.
    logic [31:0] exp_ad_out;
    logic [31:0] exp_adio_out;
    logic [31:0] exp_addr_q;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic frame_n, input logic irdy_n, input logic idsel,
                                 input logic [3:0] cbe_n, input logic [31:0] ad,
                                 input logic c_ready, input logic c_term);
        bus.FRAME_N = frame_n;
        bus.IRDY_N  = irdy_n;
        bus.IDSEL   = idsel;
        bus.CBE_N   = cbe_n;
        bus.AD_in   = ad;
        bus.c_ready = c_ready;
        bus.c_term  = c_term;
    endtask

    // Address after n completed transfers: dword index in bits 7:2 wraps mod 64.
    function automatic logic [31:0] model_addr(input logic [31:0] base, input int n);
        int unsigned dword;
        dword = ((base >> 2) + n) % 64;
        return (base & 32'hFFFF_FF03) | (dword << 2);
    endfunction

    task automatic check_reset_state(input string tag);
        checkOutput({tag, "_devsel"},   32'(bus.DEVSEL_N),   32'd1);
        checkOutput({tag, "_trdy"},     32'(bus.TRDY_N),     32'd1);
        checkOutput({tag, "_stop"},     32'(bus.STOP_N),     32'd1);
        checkOutput({tag, "_ad_oe"},    32'(bus.AD_oe),      32'd0);
        checkOutput({tag, "_ad_out"},   bus.AD_out,          32'd0);
        checkOutput({tag, "_cfg_vld"},  32'(bus.cfg_vld),    32'd0);
        checkOutput({tag, "_cfg_hit"},  32'(bus.cfg_hit),    32'd0);
        checkOutput({tag, "_s_wrdn"},   32'(bus.s_wrdn),     32'd0);
        checkOutput({tag, "_s_data"},   32'(bus.s_data),     32'd0);
        checkOutput({tag, "_data_vld"}, 32'(bus.s_data_vld), 32'd0);
        checkOutput({tag, "_addr"},     bus.addr,            32'd0);
        checkOutput({tag, "_adio_out"}, bus.adio_out,        32'd0);
    endtask

    // One complete config transaction from address phase through turnaround
    // into idle, with the user answering after ready_delay cycles per phase
    // and the initiator holding IRDY_N off for irdy_delay cycles.
    task automatic run_transaction(input bit is_write, input logic [31:0] base,
                                   input int n_phases, input int ready_delay,
                                   input int irdy_delay, input bit term_last,
                                   input logic [31:0] first_data);
        logic [31:0] data;
        bit          last;
        bit          term;

        applyStimulus(1'b0, 1'b1, 1'b1, is_write ? 4'hB : 4'hA, base, 1'b0, 1'b0);
        tick();
        exp_addr_q = base;
        checkOutput("cfg_vld",     32'(bus.cfg_vld),  32'd1);
        checkOutput("addr_latch",  bus.addr,          exp_addr_q);
        checkOutput("s_wrdn",      32'(bus.s_wrdn),   32'(is_write));
        checkOutput("decode_dsel", 32'(bus.DEVSEL_N), 32'd1);

        applyStimulus(1'b0, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
        tick();
        checkOutput("cfg_vld_once", 32'(bus.cfg_vld),  32'd0);
        checkOutput("cfg_hit",      32'(bus.cfg_hit),  32'd1);
        checkOutput("entry_devsel", 32'(bus.DEVSEL_N), 32'd0);
        checkOutput("entry_s_data", 32'(bus.s_data),   32'd1);
        checkOutput("entry_ad_oe",  32'(bus.AD_oe),    32'(!is_write));
        checkOutput("entry_trdy",   32'(bus.TRDY_N),   32'd1);

        for (int k = 0; k < n_phases; k++) begin
            last = (k == n_phases - 1);
            term = last && term_last;
            data = (k == 0) ? first_data : 32'($urandom);

            for (int w = 0; w < ready_delay; w++) begin
                tick();
                checkOutput("wait_trdy", 32'(bus.TRDY_N), 32'd1);
                checkOutput("wait_stop", 32'(bus.STOP_N), 32'd1);
            end

            if (!is_write) begin
                bus.adio_in = data;
            end
            bus.c_ready = 1'b1;
            bus.c_term  = term;
            tick();
            if (!is_write) begin
                exp_ad_out = data;
            end
            checkOutput("trdy_on",    32'(bus.TRDY_N),     32'd0);
            checkOutput("stop_data",  32'(bus.STOP_N),     32'(!term));
            checkOutput("ad_out",     bus.AD_out,          exp_ad_out);
            checkOutput("vld_idle",   32'(bus.s_data_vld), 32'd0);
            checkOutput("ph_devsel",  32'(bus.DEVSEL_N),   32'd0);

            // User pokes again while the phase is pending; it must be ignored.
            for (int w = 0; w < irdy_delay; w++) begin
                bus.c_ready = 1'b1;
                bus.c_term  = 1'b1;
                bus.adio_in = ~data;
                tick();
                checkOutput("hold_trdy",   32'(bus.TRDY_N),     32'd0);
                checkOutput("hold_stop",   32'(bus.STOP_N),     32'(!term));
                checkOutput("hold_ad_out", bus.AD_out,          exp_ad_out);
                checkOutput("hold_vld",    32'(bus.s_data_vld), 32'd0);
            end

            // Transfer edge; the user's new answer on this edge must not count.
            applyStimulus(last && !term, 1'b0, 1'b0, 4'h0,
                          is_write ? data : 32'($urandom), 1'b1, 1'b1);
            tick();
            exp_addr_q = model_addr(base, k + 1);
            if (is_write) begin
                exp_adio_out = data;
            end
            checkOutput("s_data_vld", 32'(bus.s_data_vld), 32'd1);
            checkOutput("addr_inc",   bus.addr,            exp_addr_q);
            checkOutput("adio_out",   bus.adio_out,        exp_adio_out);
            checkOutput("post_trdy",  32'(bus.TRDY_N),     32'd1);
            checkOutput("post_stop",  32'(bus.STOP_N),     32'd1);
            if (last) begin
                checkOutput("turn_devsel", 32'(bus.DEVSEL_N), 32'd1);
                checkOutput("turn_s_data", 32'(bus.s_data),   32'd0);
                checkOutput("turn_ad_oe",  32'(bus.AD_oe),    32'd0);
            end else begin
                checkOutput("burst_devsel", 32'(bus.DEVSEL_N), 32'd0);
                checkOutput("burst_s_data", 32'(bus.s_data),   32'd1);
            end
            applyStimulus(last, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
        end

        tick();
        checkOutput("idle_vld",    32'(bus.s_data_vld), 32'd0);
        checkOutput("idle_devsel", 32'(bus.DEVSEL_N),   32'd1);
        checkOutput("idle_s_data", 32'(bus.s_data),     32'd0);
        checkOutput("idle_addr",   bus.addr,            exp_addr_q);
    endtask

    initial begin
        logic [31:0] rnd_base;

        exp_ad_out   = 32'd0;
        exp_adio_out = 32'd0;
        exp_addr_q   = 32'd0;
        bus.adio_in  = 32'd0;
        applyStimulus(1'b1, 1'b1, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0);

        // Reset state
        reset_n = 1'b0;
        tick();
        tick();
        check_reset_state("reset");
        reset_n = 1'b1;
        tick();
        checkOutput("post_reset_vld", 32'(bus.cfg_vld), 32'd0);

        // Write with disconnect-with-data three cycles after cfg_hit
        run_transaction(1'b1, 32'h0000_0080, 1, 3, 0, 1'b1, 32'hDEAD_BEEF);

        // Read, back-to-back, with one IRDY wait state
        run_transaction(1'b0, 32'h0000_0080, 1, 2, 1, 1'b0, 32'h1234_5678);

        // Two-phase write burst wrapping 0xFC -> 0x00, IRDY held off two cycles
        run_transaction(1'b1, 32'h0000_00FC, 2, 0, 2, 1'b0, 32'hA5A5_0001);

        // Slow user across a burst: watchdog must restart after each transfer
        run_transaction(1'b0, 32'h0000_01F8, 3, 10, 0, 1'b0, 32'h0BAD_F00D);

        // Retry: c_term alone, later c_ready ignored, no data moved
        applyStimulus(1'b0, 1'b1, 1'b1, 4'hA, 32'h0000_0040, 1'b0, 1'b0);
        tick();
        exp_addr_q = 32'h0000_0040;
        checkOutput("retry_cfg_vld", 32'(bus.cfg_vld), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1);
        tick();
        checkOutput("retry_stop",   32'(bus.STOP_N),   32'd0);
        checkOutput("retry_trdy",   32'(bus.TRDY_N),   32'd1);
        checkOutput("retry_devsel", 32'(bus.DEVSEL_N), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0);
        tick();
        checkOutput("retry_no_trdy", 32'(bus.TRDY_N),     32'd1);
        checkOutput("retry_no_vld",  32'(bus.s_data_vld), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
        tick();
        checkOutput("retry_turn_stop", 32'(bus.STOP_N),     32'd1);
        checkOutput("retry_turn_vld",  32'(bus.s_data_vld), 32'd0);
        checkOutput("retry_addr",      bus.addr,            exp_addr_q);
        tick();

        // Target abort after 16 silent cycles in DATA
        applyStimulus(1'b0, 1'b1, 1'b1, 4'hB, 32'h0000_0080, 1'b0, 1'b0);
        tick();
        exp_addr_q = 32'h0000_0080;
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
        tick();
        checkOutput("wd_cfg_hit", 32'(bus.cfg_hit), 32'd1);
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (c < 16) begin
                checkOutput("wd_quiet_stop", 32'(bus.STOP_N), 32'd1);
            end
        end
        checkOutput("wd_abort_stop",   32'(bus.STOP_N),   32'd0);
        checkOutput("wd_abort_devsel", 32'(bus.DEVSEL_N), 32'd1);
        checkOutput("wd_abort_trdy",   32'(bus.TRDY_N),   32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0);
        tick();
        checkOutput("wd_hold_trdy", 32'(bus.TRDY_N), 32'd1);
        checkOutput("wd_hold_stop", 32'(bus.STOP_N), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
        tick();
        checkOutput("wd_turn_stop", 32'(bus.STOP_N),     32'd1);
        checkOutput("wd_turn_vld",  32'(bus.s_data_vld), 32'd0);
        checkOutput("wd_turn_sdat", 32'(bus.s_data),     32'd0);
        tick();
        checkOutput("wd_idle_vld", 32'(bus.s_data_vld), 32'd0);

        // Non-config cycles: IDSEL=0 goes BUSY; BUSY needs FRAME_N and IRDY_N high
        applyStimulus(1'b0, 1'b1, 1'b0, 4'hA, 32'h0000_0100, 1'b0, 1'b0);
        tick();
        checkOutput("busy_no_vld", 32'(bus.cfg_vld),  32'd0);
        checkOutput("busy_addr",   bus.addr,          exp_addr_q);
        checkOutput("busy_devsel", 32'(bus.DEVSEL_N), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b1, 4'hB, 32'h0000_0100, 1'b0, 1'b0);
        tick();
        checkOutput("busy_hold_vld", 32'(bus.cfg_vld), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b1, 4'h6, 32'h0000_0100, 1'b0, 1'b0);
        tick();
        checkOutput("cbe6_no_vld", 32'(bus.cfg_vld), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b1, 4'hA, 32'h0000_0101, 1'b0, 1'b0);
        tick();
        checkOutput("misalign_no_vld", 32'(bus.cfg_vld), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
        tick();
        run_transaction(1'b0, 32'h0000_0010, 1, 0, 0, 1'b0, 32'hCAFE_0010);

        // Reset during DATA with a transfer pending on the same edge
        applyStimulus(1'b0, 1'b1, 1'b1, 4'hB, 32'h0000_0A40, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 32'h5555_AAAA, 1'b1, 1'b0);
        tick();
        tick();
        checkOutput("pre_rst_trdy", 32'(bus.TRDY_N), 32'd0);
        reset_n     = 1'b0;
        bus.c_ready = 1'b0;
        tick();
        check_reset_state("mid_rst");
        exp_ad_out   = 32'd0;
        exp_adio_out = 32'd0;
        exp_addr_q   = 32'd0;
        reset_n = 1'b1;
        run_transaction(1'b1, 32'h0000_0A40, 1, 1, 0, 1'b0, 32'h0F0F_F0F0);

        // Randomized transactions
        for (int t = 0; t < 12; t++) begin
            rnd_base = 32'($urandom) & 32'hFFFF_FFFC;
            if ($urandom_range(0, 2) == 0) begin
                rnd_base = rnd_base | 32'h0000_00F0;
            end
            run_transaction(1'($urandom_range(0, 1)), rnd_base,
                            int'($urandom_range(1, 3)), int'($urandom_range(0, 6)),
                            int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                            32'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pci_cfg_front.md
PCI_CFG_FRONT -- requirements
Module: pci_cfg_front

Interface
REQ-001 SHALL have ports: CLK in 1, sole clock, all state on rising edge; reset_n in 1, synchronous active-low reset.
REQ-002 SHALL have PCI-side inputs: FRAME_N 1, IRDY_N 1, IDSEL 1, CBE_N 4, AD_in 32 (sampled bus AD).
REQ-003 SHALL have PCI-side outputs: DEVSEL_N 1, TRDY_N 1, STOP_N 1, AD_out 32 (read data), AD_oe 1 (AD drive enable).
REQ-004 SHALL have user-side outputs: cfg_vld 1, cfg_hit 1, s_wrdn 1 (1=write), s_data 1, s_data_vld 1, addr 32, adio_out 32 (write data).
REQ-005 SHALL have user-side inputs: adio_in 32 (read data), c_ready 1, c_term 1.

Function
REQ-006 SHALL implement states IDLE, DECODE, DATA, TURN, BUSY; all outputs registered.
REQ-007 IDLE: edge with FRAME_N=0 and IDSEL=1 and CBE_N in {4'hA read, 4'hB write} and AD_in[1:0]=2'b00 SHALL latch addr<=AD_in, s_wrdn<=CBE_N[0], assert cfg_vld for exactly one cycle, go DECODE.
REQ-008 IDLE: edge with FRAME_N=0 not meeting REQ-007 SHALL go BUSY with no output change.
REQ-009 BUSY SHALL return to IDLE on first edge with FRAME_N=1 and IRDY_N=1.
REQ-010 DECODE -> DATA unconditionally next edge; entering DATA SHALL pulse cfg_hit one cycle, set DEVSEL_N=0, s_data=1, AD_oe=!s_wrdn, clear watchdog.
REQ-011 DATA, TRDY_N=1 and STOP_N=1: sampled c_ready=1 SHALL set TRDY_N<=0; c_term=1 SHALL set STOP_N<=0; both = disconnect-with-data; AD_out<=adio_in on the same edge c_ready is sampled (reads).
REQ-012 Once TRDY_N or STOP_N asserted, c_ready/c_term SHALL be ignored until that phase completes.
REQ-013 Transfer = edge with TRDY_N=0 and IRDY_N=0: SHALL pulse s_data_vld next cycle, adio_out<=AD_in (writes only), addr[7:2]<=addr[7:2]+1 wrapping 6'h3F->6'h00 (addr[31:8], [1:0] unchanged), clear watchdog.
REQ-014 On transfer edge with STOP_N=0 or FRAME_N=1 SHALL go TURN; otherwise TRDY_N<=1, STOP_N stays 1, remain DATA.
REQ-015 With STOP_N=0 and TRDY_N=1 SHALL hold until edge with FRAME_N=1, then go TURN (retry/disconnect without data, no s_data_vld).
REQ-016 Watchdog 5-bit SHALL count edges in DATA while TRDY_N=1 and STOP_N=1; on reaching 16 SHALL set STOP_N<=0, DEVSEL_N<=1 (target abort), then behave per REQ-015.
REQ-017 TURN SHALL last one cycle with DEVSEL_N=TRDY_N=STOP_N=1, AD_oe=0, s_data=0, then IDLE; s_data falls on the edge entering TURN.
REQ-018 FRAME_N low in IDLE immediately after TURN SHALL be decoded normally (back-to-back).
REQ-019 Simultaneous c_ready/c_term sampling and transfer edge: transfer handled per REQ-013/014; new c_ready/c_term considered only on following edge.

Reset
REQ-020 reset_n=0 at edge SHALL force IDLE, DEVSEL_N=TRDY_N=STOP_N=1, AD_oe=0, AD_out=0, cfg_vld=cfg_hit=s_data=s_data_vld=0, s_wrdn=0, addr=0, adio_out=0, watchdog=0.
REQ-021 Reset mid-transaction SHALL take precedence over all state transitions; after release block SHALL sit in IDLE and ignore an in-progress FRAME_N=0 only if IDSEL/CBE_N fail REQ-007.

Verification
REQ-022 Config write, AD=0x0000_0080, CBE_N=B, one data 0xDEAD_BEEF, user c_ready=c_term=1 three cycles after cfg_hit -> TRDY_N=STOP_N=0 together, s_data_vld one cycle, adio_out=0xDEAD_BEEF, TURN then IDLE.
REQ-023 Config read addr 0x80, adio_in=0x1234_5678 -> AD_oe=1 from DATA entry, AD_out=0x1234_5678 when TRDY_N=0, AD_oe=0 in TURN.
REQ-024 Two-phase write burst, c_ready only (c_term=0), IRDY_N held high 2 cycles -> TRDY_N held low until IRDY_N=0; addr 0xFC then 0x00 (wrap), two s_data_vld pulses.
REQ-025 No c_ready/c_term for 16 cycles after cfg_hit -> STOP_N=0, DEVSEL_N=1 at cycle 16; FRAME_N=1 -> TURN, no s_data_vld.
REQ-026 IDSEL=0 or CBE_N=6 address phase -> no cfg_vld, state BUSY until FRAME_N=IRDY_N=1; reset_n=0 during DATA -> all outputs per REQ-020 next edge.
